// File: rtl/hilo_mul_sequencer.sv
// HI/LO register owner for the MIPS32 datapath: iterative 32-cycle shift-add
// multiply with mult/multu/madd/msub accumulation and single-cycle mthi/mtlo.
module hilo_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, FIX, ACC} state_t;

    state_t             state_reg, state_next;
    logic [2*WIDTH-1:0] mcand_reg, mcand_next;
    logic [WIDTH-1:0]   mplier_reg, mplier_next;
    logic [2*WIDTH-1:0] prod_reg, prod_next;
    logic [5:0]         cnt_reg, cnt_next;
    logic               neg_reg, neg_next;
    logic [1:0]         op_reg, op_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               done_reg, done_next;

    logic               signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] hilo;

    // multu is the only multiply that works on raw operands
    assign signed_op = (op[1:0] != 2'b01);
    assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign hilo      = {hi_reg, lo_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            op_reg     <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            prod_reg   <= prod_next;
            cnt_reg    <= cnt_next;
            neg_reg    <= neg_next;
            op_reg     <= op_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        prod_next   = prod_reg;
        cnt_next    = cnt_reg;
        neg_next    = neg_reg;
        op_next     = op_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !cancel) begin
                    if (!op[2]) begin
                        mcand_next  = {{WIDTH{1'b0}}, mag_a};
                        mplier_next = mag_b;
                        neg_next    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        op_next     = op[1:0];
                        prod_next   = '0;
                        cnt_next    = '0;
                        state_next  = MUL;
                    end else if (!op[1]) begin
                        if (op[0]) lo_next = a;
                        else       hi_next = a;
                        done_next = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    if (mplier_reg[0]) prod_next = prod_reg + mcand_reg;
                    mplier_next = mplier_reg >> 1;
                    mcand_next  = mcand_reg << 1;
                    cnt_next    = cnt_reg + 6'd1;
                    if (cnt_reg == 6'(WIDTH - 1)) state_next = FIX;
                end
            end
            FIX: begin
                if (cancel) begin
                    state_next = IDLE;
                end else begin
                    if (neg_reg) prod_next = -prod_reg;
                    state_next = ACC;
                end
            end
            ACC: begin
                state_next = IDLE;
                if (!cancel) begin
                    case (op_reg)
                        2'b10:   {hi_next, lo_next} = hilo + prod_reg;
                        2'b11:   {hi_next, lo_next} = hilo - prod_reg;
                        default: {hi_next, lo_next} = prod_reg;
                    endcase
                    done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Directed bench for hilo_mul_sequencer: each task drives one scenario and checks inline.
module tb_hilo_mul_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    hilo_mul_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle Start pulse; returns at the falling edge of cycle 1.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = 32'h0; b = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, want 0 0 0 0", hi, lo, busy, done);
        end
        rst_n = 1'b1;
        $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    endtask

    task automatic test_mult_signed();
        int busy_bad = 0;
        issue(3'b000, 32'hFFFFFFFD, 32'd5);
        for (int c = 1; c <= 34; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
                errors++;
                busy_bad++;
                $display("FAIL mult_busy cycle %0d: busy=%b done=%b hi=%h lo=%h, want 1 0 0 0", c, busy, done, hi, lo);
            end
        end
        @(negedge clk);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_result: hi=%h lo=%h done=%b busy=%b, want ffffffff fffffff1 1 0", hi, lo, done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_pulse: done=%b, want 0", done);
        end
        $display("mult -3*5: hi=%h lo=%h busy_errors=%0d", hi, lo, busy_bad);
    endtask

    task automatic test_multu_mult();
        issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (34) @(negedge clk);
        checks++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001 || done !== 1'b1) begin
            errors++;
            $display("FAIL multu_max: hi=%h lo=%h done=%b, want fffffffe 00000001 1", hi, lo, done);
        end
        $display("multu ffffffff^2: hi=%h lo=%h", hi, lo);
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (34) @(negedge clk);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h1 || done !== 1'b1) begin
            errors++;
            $display("FAIL mult_m1: hi=%h lo=%h done=%b, want 0 1 1", hi, lo, done);
        end
        $display("mult -1*-1: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_madd_msub();
        issue(3'b100, 32'h0, 32'h0);
        checks++;
        if (hi !== 32'h0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h done=%b busy=%b, want 0 1 0", hi, done, busy);
        end
        issue(3'b101, 32'd10, 32'h0);
        checks++;
        if (lo !== 32'd10 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: lo=%h done=%b busy=%b, want 0000000a 1 0", lo, done, busy);
        end
        issue(3'b010, 32'd2, 32'd3);
        repeat (34) @(negedge clk);
        checks++;
        if (hi !== 32'h0 || lo !== 32'd16 || done !== 1'b1) begin
            errors++;
            $display("FAIL madd: hi=%h lo=%h done=%b, want 0 00000010 1", hi, lo, done);
        end
        $display("madd 2*3 onto 10: hi=%h lo=%h", hi, lo);
        issue(3'b011, 32'h80000000, 32'd2);
        repeat (34) @(negedge clk);
        checks++;
        if (hi !== 32'h1 || lo !== 32'h10 || done !== 1'b1) begin
            errors++;
            $display("FAIL msub: hi=%h lo=%h done=%b, want 00000001 00000010 1", hi, lo, done);
        end
        $display("msub 0x80000000*2: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_cancel_and_busy_start();
        // cancelled run: Start in cycle 5 ignored, Cancel in cycle 10
        issue(3'b000, 32'd7, 32'd9);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; a = '0;
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h1 || lo !== 32'h10) begin
            errors++;
            $display("FAIL cancel_state: busy=%b hi=%h lo=%h, want 0 00000001 00000010", busy, hi, lo);
        end
        for (int c = 11; c <= 36; c++) begin
            checks++;
            if (done !== 1'b0 || hi !== 32'h1 || lo !== 32'h10) begin
                errors++;
                $display("FAIL cancel_quiet cycle %0d: done=%b hi=%h lo=%h, want 0 00000001 00000010", c, done, hi, lo);
            end
            @(negedge clk);
        end
        $display("cancelled mult 7*9: hi=%h lo=%h busy=%b", hi, lo, busy);
        // full run with the ignored Start in cycle 5
        issue(3'b000, 32'd7, 32'd9);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; a = '0;
        checks++;
        if (busy !== 1'b1 || hi !== 32'h1) begin
            errors++;
            $display("FAIL busy_start_ignored: busy=%b hi=%h, want 1 00000001", busy, hi);
        end
        repeat (29) @(negedge clk);
        checks++;
        if (hi !== 32'h0 || lo !== 32'd63 || done !== 1'b1) begin
            errors++;
            $display("FAIL mult_7x9: hi=%h lo=%h done=%b, want 0 0000003f 1", hi, lo, done);
        end
        $display("mult 7*9: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_async_reset();
        issue(3'b100, 32'h5555, 32'h0);
        issue(3'b000, 32'd3, 32'd3);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b, want 0 0 0 0", hi, lo, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b000, 32'h10000, 32'h10000);
        repeat (34) @(negedge clk);
        checks++;
        if (hi !== 32'h1 || lo !== 32'h0 || done !== 1'b1) begin
            errors++;
            $display("FAIL mult_after_reset: hi=%h lo=%h done=%b, want 00000001 0 1", hi, lo, done);
        end
        $display("async reset then mult 0x10000^2: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_invalid_and_cancel_idle();
        issue(3'b110, 32'h77, 32'h1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h1 || lo !== 32'h0) begin
            errors++;
            $display("FAIL invalid_op: busy=%b done=%b hi=%h lo=%h, want 0 0 00000001 0", busy, done, hi, lo);
        end
        @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'h1234; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        checks++;
        if (lo !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mtlo_cancel: lo=%h done=%b, want 0 0", lo, done);
        end
        $display("invalid op / cancelled mtlo: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h11;
        @(negedge clk);
        a = 32'h22;
        checks++;
        if (hi !== 32'h11 || done !== 1'b1) begin
            errors++;
            $display("FAIL mthi_first: hi=%h done=%b, want 00000011 1", hi, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hi !== 32'h22 || done !== 1'b1) begin
            errors++;
            $display("FAIL mthi_second: hi=%h done=%b, want 00000022 1", hi, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mthi_done_end: done=%b, want 0", done);
        end
        // new Start accepted in the Done cycle
        issue(3'b000, 32'd3, 32'd4);
        repeat (34) @(negedge clk);
        checks++;
        if (lo !== 32'd12 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: lo=%h done=%b, want 0000000c 1", lo, done);
        end
        start = 1'b1; op = 3'b001; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b, want 1", busy);
        end
        repeat (34) @(negedge clk);
        checks++;
        if (hi !== 32'h0 || lo !== 32'd30 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: hi=%h lo=%h done=%b, want 0 0000001e 1", hi, lo, done);
        end
        $display("back-to-back: hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu_mult();
        test_madd_msub();
        test_cancel_and_busy_start();
        test_async_reset();
        test_invalid_and_cancel_idle();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_mul_sequencer.md
# hilo_mul_sequencer

Multi-cycle multiply/accumulate sequencer that owns the architectural HI and LO registers for the MIPS32 datapath. It executes mult, multu, madd and msub as an iterative radix-2 shift-add over 32 cycles, and executes mthi and mtlo in a single cycle. It sits beside the execute-stage ALU. The pipeline reads Hi/Lo directly for mfhi/mflo and must stall on Busy.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits. Only 32 is required.
- Clk  in  1  rising-edge clock; the block's only clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe, sampled on the rising edge.
- Op  in  3  operation select: 000 mult, 001 multu, 010 madd, 011 msub, 100 mthi, 101 mtlo. Codes 110 and 111 are invalid.
- A  in  32  rs operand.
- B  in  32  rt operand.
- Cancel  in  1  abort the in-flight operation (pipeline flush).
- Busy  out  1  high while a multi-cycle operation is in flight.
- Done  out  1  one-cycle pulse in the first cycle the new HI/LO value is visible.
- Hi  out  32  architectural HI register.
- Lo  out  32  architectural LO register.

## Operation
- States: IDLE, MUL, FIX, ACC. Busy = (state != IDLE).
- **IDLE**
  - If Start is high, Cancel is low and Op is 000–011:
    - Latch magnitudes |A| and |B|. For multu the magnitudes are the raw operands.
    - Latch neg = signed op & (A[31] ^ B[31]).
    - Latch Op. Clear the 64-bit product and the 6-bit counter.
    - Go to MUL.
  - If Start is high, Cancel is low and Op is 100/101: write A to Hi (100) or to Lo (101) on this edge, pulse Done next cycle, stay in IDLE.
  - Op 110/111: Start is ignored, no Done.
- **MUL:** each cycle, if multiplier bit 0 is 1, add the shifted multiplicand into the product. Then shift the multiplier right and the multiplicand left, and increment the counter. After the 32nd iteration (counter = 31) go to FIX.
- **FIX:** if neg, product = two's-complement negation of the product (64-bit). Go to ACC.
- **ACC:** on the exit edge, write {Hi,Lo} and go to IDLE with Done = 1:
  - mult/multu: {Hi,Lo} = product.
  - madd: {Hi,Lo} = {Hi,Lo} + product, mod 2^64.
  - msub: {Hi,Lo} = {Hi,Lo} − product, mod 2^64.
- Arithmetic:
  - mult, madd and msub use the signed product.
  - multu uses the unsigned product.
  - Overflow wraps silently; there is no exception.
  - Operands are captured at Start; later changes on A/B have no effect.
- Start while Busy is ignored: no capture and no effect on the in-flight operation. The pipeline guarantees a stall.
- Cancel:
  - Cancel while Busy: return to IDLE on the next edge. Hi/Lo are unchanged and there is no Done.
  - Cancel in IDLE: overrides Start, so nothing is written.
  - Cancel with Start in the Done cycle: Start is ignored.
- Reset, asynchronous, including mid-operation: state = IDLE, Hi = 0, Lo = 0, Busy = 0, Done = 0. Internal operand, product and counter registers are cleared.

## Timing
- Start of mult/multu/madd/msub sampled high in cycle 0:
  - Busy is high in cycles 1–34 (MUL in cycles 1–32, FIX in 33, ACC in 34).
  - New Hi/Lo and Done = 1 in cycle 35, with Busy = 0.
  - Latency: 35 cycles.
- A new Start is accepted in the Done cycle (cycle 35). Back-to-back throughput is one operation per 35 cycles.
- mthi/mtlo Start sampled in cycle 0: Hi/Lo are updated in cycle 1, Done = 1 in cycle 1, and Busy stays 0.
- Done is registered and never high for two consecutive cycles from one request. Two mthi requests in consecutive cycles produce Done in two consecutive cycles.
- Hi and Lo change only on an ACC exit edge, an mthi/mtlo edge, or reset. They are stable at all other times, including during MUL and FIX.

## Test plan
- Reset low for 3 cycles, then release; mult A=0xFFFFFFFD (−3), B=5 -> Busy high in cycles 1–34; in cycle 35 Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, Done=1 for exactly one cycle.
- multu A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Then mult on the same operands -> Hi=0, Lo=1.
- mthi 0, mtlo 10, then madd A=2, B=3 -> Lo=16, Hi=0. Then msub A=0x80000000, B=2 -> {Hi,Lo}=0x0000_0001_0000_0010.
- mult 7×9 started; Cancel pulsed in cycle 10 -> Busy=0 from cycle 11, Hi/Lo keep their prior values, no Done. Start pulsed in cycle 5 (while Busy) -> ignored, and a completed mult still gives Lo=63 in cycle 35.
- Reset asserted asynchronously in cycle 20 of a mult (mid-clock) -> Hi=Lo=0 and Busy=0 immediately. After release, a new mult 0x10000×0x10000 -> Hi=1, Lo=0.
- Start with Op=110 -> no state change and no Done. mtlo 0x1234 with Cancel=1 -> Lo unchanged.
